// File: rtl/control_pkg.sv
`default_nettype none
// ============================================================================
// Module      : control_pkg
// Description : Microcode bit indices, ALU/branch enums and RV32I opcodes
//               shared by the decode stage and the control unit.
// Revision    : 1.0 - initial release
// ============================================================================
package control_pkg;

    localparam int c_mc_chk_rs1        = 0;
    localparam int c_mc_chk_rs2        = 1;
    localparam int c_mc_rega_alu_a     = 2;
    localparam int c_mc_up_alu_a       = 3;
    localparam int c_mc_jt_alu_a       = 4;
    localparam int c_mc_bt_alu_a       = 5;
    localparam int c_mc_regb_alu_b     = 6;
    localparam int c_mc_li_alu_b       = 7;
    localparam int c_mc_st_alu_b       = 8;
    localparam int c_mc_pc_alu_b       = 9;
    localparam int c_mc_rs2_alu_b      = 10;
    localparam int c_mc_mem_we         = 11;
    localparam int c_mc_alu_mem_addr   = 12;
    localparam int c_mc_regb_mem_data  = 13;
    localparam int c_mc_jump_if_branch = 14;
    localparam int c_mc_mem_in_use     = 15;
    localparam int c_mc_reg_we         = 16;
    localparam int c_mc_up_rd          = 17;
    localparam int c_mc_alu_rd         = 18;
    localparam int c_mc_ret_rd         = 19;
    localparam int c_mc_mem_rd         = 20;
    localparam int c_mc_byte           = 21;
    localparam int c_mc_half           = 22;
    localparam int c_mc_sbyte          = 23;
    localparam int c_mc_shalf          = 24;
    localparam int c_mc_alu_lsb        = 25;
    localparam int c_mc_cond_lsb       = 29;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    typedef enum logic [2:0] {
        BR_NEVER  = 3'b000,
        BR_EQ     = 3'b001,
        BR_NE     = 3'b010,
        BR_LT     = 3'b011,
        BR_GE     = 3'b100,
        BR_LTU    = 3'b101,
        BR_GEU    = 3'b110,
        BR_ALWAYS = 3'b111
    } branch_cond_e;

    localparam logic [6:0] c_opc_lui      = 7'b0110111;
    localparam logic [6:0] c_opc_auipc    = 7'b0010111;
    localparam logic [6:0] c_opc_jal      = 7'b1101111;
    localparam logic [6:0] c_opc_jalr     = 7'b1100111;
    localparam logic [6:0] c_opc_branch   = 7'b1100011;
    localparam logic [6:0] c_opc_load     = 7'b0000011;
    localparam logic [6:0] c_opc_store    = 7'b0100011;
    localparam logic [6:0] c_opc_op_imm   = 7'b0010011;
    localparam logic [6:0] c_opc_op       = 7'b0110011;
    localparam logic [6:0] c_opc_misc_mem = 7'b0001111;
    localparam logic [6:0] c_opc_system   = 7'b1110011;

    // alt selects SUB for funct3 000 and SRA for funct3 101
    function automatic alu_op_e f3_to_alu(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/inst_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : inst_decoder_if
// Description : Fetch-side inputs and s0 outputs of the decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface inst_decoder_if;
    logic [31:0] instruction;
    logic        block_inst;
    logic        jump_taken;
    logic [31:0] microcode_s0;
    logic [24:0] instruction_data_s0;
    logic        illegal_inst;

    modport master (
        output instruction, block_inst, jump_taken,
        input  microcode_s0, instruction_data_s0, illegal_inst
    );

    modport slave (
        input  instruction, block_inst, jump_taken,
        output microcode_s0, instruction_data_s0, illegal_inst
    );
endinterface
`default_nettype wire

// File: rtl/microcode_rom.sv
`default_nettype none
// ============================================================================
// Module      : microcode_rom
// Description : Combinational RV32I instruction -> microcode word + illegal.
// Revision    : 1.0 - initial release
// ============================================================================
module microcode_rom
    import control_pkg::*;
(
    input  wire logic [31:0] i_instruction,
    output logic      [31:0] o_microcode,
    output logic             o_illegal
);
    logic [6:0]   w_opcode;
    logic [2:0]   w_funct3;
    logic         w_alt;
    logic         w_unused_bits;
    logic [31:0]  w_mc;
    logic         w_illegal;
    alu_op_e      w_alu;
    branch_cond_e w_cond;

    assign w_opcode      = i_instruction[6:0];
    assign w_funct3      = i_instruction[14:12];
    assign w_alt         = i_instruction[30];
    assign w_unused_bits = &{1'b0, i_instruction[31], i_instruction[29:15], i_instruction[11:7]};

    always_comb begin
        w_mc      = '0;
        w_illegal = 1'b0;
        w_alu     = ALU_ADD;
        w_cond    = BR_NEVER;
        case (w_opcode)
            c_opc_lui: begin
                w_mc[c_mc_reg_we] = 1'b1;
                w_mc[c_mc_up_rd]  = 1'b1;
            end
            c_opc_auipc: begin
                w_mc[c_mc_up_alu_a] = 1'b1;
                w_mc[c_mc_pc_alu_b] = 1'b1;
                w_mc[c_mc_reg_we]   = 1'b1;
                w_mc[c_mc_alu_rd]   = 1'b1;
            end
            c_opc_jal: begin
                w_mc[c_mc_jt_alu_a]       = 1'b1;
                w_mc[c_mc_pc_alu_b]       = 1'b1;
                w_mc[c_mc_jump_if_branch] = 1'b1;
                w_mc[c_mc_reg_we]         = 1'b1;
                w_mc[c_mc_ret_rd]         = 1'b1;
                w_cond                    = BR_ALWAYS;
            end
            c_opc_jalr: begin
                w_mc[c_mc_chk_rs1]        = 1'b1;
                w_mc[c_mc_rega_alu_a]     = 1'b1;
                w_mc[c_mc_li_alu_b]       = 1'b1;
                w_mc[c_mc_jump_if_branch] = 1'b1;
                w_mc[c_mc_reg_we]         = 1'b1;
                w_mc[c_mc_ret_rd]         = 1'b1;
                w_cond                    = BR_ALWAYS;
            end
            c_opc_branch: begin
                w_mc[c_mc_chk_rs1]        = 1'b1;
                w_mc[c_mc_chk_rs2]        = 1'b1;
                w_mc[c_mc_bt_alu_a]       = 1'b1;
                w_mc[c_mc_pc_alu_b]       = 1'b1;
                w_mc[c_mc_jump_if_branch] = 1'b1;
                case (w_funct3)
                    3'b000:  w_cond = BR_EQ;
                    3'b001:  w_cond = BR_NE;
                    3'b100:  w_cond = BR_LT;
                    3'b101:  w_cond = BR_GE;
                    3'b110:  w_cond = BR_LTU;
                    3'b111:  w_cond = BR_GEU;
                    default: w_illegal = 1'b1;
                endcase
            end
            c_opc_load: begin
                w_mc[c_mc_chk_rs1]      = 1'b1;
                w_mc[c_mc_rega_alu_a]   = 1'b1;
                w_mc[c_mc_li_alu_b]     = 1'b1;
                w_mc[c_mc_alu_mem_addr] = 1'b1;
                w_mc[c_mc_mem_in_use]   = 1'b1;
                w_mc[c_mc_reg_we]       = 1'b1;
                w_mc[c_mc_mem_rd]       = 1'b1;
                case (w_funct3)
                    3'b000:  w_mc[c_mc_sbyte] = 1'b1;
                    3'b001:  w_mc[c_mc_shalf] = 1'b1;
                    3'b010:  ;
                    3'b100:  w_mc[c_mc_byte]  = 1'b1;
                    3'b101:  w_mc[c_mc_half]  = 1'b1;
                    default: w_illegal = 1'b1;
                endcase
            end
            c_opc_store: begin
                w_mc[c_mc_chk_rs1]       = 1'b1;
                w_mc[c_mc_chk_rs2]       = 1'b1;
                w_mc[c_mc_rega_alu_a]    = 1'b1;
                w_mc[c_mc_st_alu_b]      = 1'b1;
                w_mc[c_mc_mem_we]        = 1'b1;
                w_mc[c_mc_alu_mem_addr]  = 1'b1;
                w_mc[c_mc_regb_mem_data] = 1'b1;
                w_mc[c_mc_mem_in_use]    = 1'b1;
                case (w_funct3)
                    3'b000:  w_mc[c_mc_byte] = 1'b1;
                    3'b001:  w_mc[c_mc_half] = 1'b1;
                    3'b010:  ;
                    default: w_illegal = 1'b1;
                endcase
            end
            c_opc_op_imm: begin
                w_mc[c_mc_chk_rs1]    = 1'b1;
                w_mc[c_mc_rega_alu_a] = 1'b1;
                w_mc[c_mc_reg_we]     = 1'b1;
                w_mc[c_mc_alu_rd]     = 1'b1;
                // Shift-immediates take the 5-bit shamt path instead of the full immediate
                if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
                    w_mc[c_mc_rs2_alu_b] = 1'b1;
                end else begin
                    w_mc[c_mc_li_alu_b]  = 1'b1;
                end
                w_alu = f3_to_alu(w_funct3, w_alt && (w_funct3 == 3'b101));
            end
            c_opc_op: begin
                w_mc[c_mc_chk_rs1]     = 1'b1;
                w_mc[c_mc_chk_rs2]     = 1'b1;
                w_mc[c_mc_rega_alu_a]  = 1'b1;
                w_mc[c_mc_regb_alu_b]  = 1'b1;
                w_mc[c_mc_reg_we]      = 1'b1;
                w_mc[c_mc_alu_rd]      = 1'b1;
                w_alu = f3_to_alu(w_funct3, w_alt);
            end
            c_opc_misc_mem, c_opc_system: ;
            default: w_illegal = 1'b1;
        endcase
        w_mc[c_mc_alu_lsb +: 4]  = w_alu;
        w_mc[c_mc_cond_lsb +: 3] = w_cond;
        if (w_illegal) begin
            w_mc = '0;
        end
    end

    assign o_microcode = w_mc;
    assign o_illegal   = w_illegal;

endmodule
`default_nettype wire

// File: rtl/inst_decoder.sv
`default_nettype none
// ============================================================================
// Module      : inst_decoder
// Description : Registered decode stage with bubble insertion on block, jump
//               flush and illegal opcodes. Trap/halt enabled by macro
//               INST_DECODER_ILLEGAL_TRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_decoder
    import control_pkg::*;
#(
    parameter int FLUSH_DEPTH = 3
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    inst_decoder_if.slave  bus
);
    localparam int                 c_cnt_w      = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;
    localparam logic [c_cnt_w-1:0] c_flush_load = c_cnt_w'(FLUSH_DEPTH - 1);

    logic [31:0]        w_mc;
    logic               w_illegal;
    logic               w_halt;
    logic               w_squash;
    logic [31:0]        r_mc;
    logic [24:0]        r_data;
    logic [c_cnt_w-1:0] r_flush_cnt;

    microcode_rom u_rom (
        .i_instruction (bus.instruction),
        .o_microcode   (w_mc),
        .o_illegal     (w_illegal)
    );

`ifdef INST_DECODER_ILLEGAL_TRAP_EN
    logic r_illegal;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_illegal <= 1'b0;
        end else if (!w_squash && w_illegal) begin
            r_illegal <= 1'b1;
        end
    end

    assign w_halt           = r_illegal;
    assign bus.illegal_inst = r_illegal;
`else
    assign w_halt           = 1'b0;
    assign bus.illegal_inst = 1'b0;
`endif

    // Only registered state and same-edge inputs feed the load; no comb path to outputs
    assign w_squash = w_halt || bus.jump_taken || (r_flush_cnt != '0) || bus.block_inst;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mc        <= '0;
            r_data      <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (bus.jump_taken) begin
                r_flush_cnt <= c_flush_load;
            end else if (r_flush_cnt != '0) begin
                r_flush_cnt <= r_flush_cnt - c_cnt_w'(1);
            end
            if (w_squash || w_illegal) begin
                r_mc   <= '0;
                r_data <= '0;
            end else begin
                r_mc   <= w_mc;
                r_data <= bus.instruction[31:7];
            end
        end
    end

    assign bus.microcode_s0        = r_mc;
    assign bus.instruction_data_s0 = r_data;

endmodule
`default_nettype wire

// File: tb/tb_inst_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_decoder
// Description : Directed bench for inst_decoder with a cycle-level reference
//               model plus literal spot checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_decoder;
    localparam int FLUSH_DEPTH = 3;

    localparam logic [31:0] ADDI  = 32'h00500093;
    localparam logic [31:0] LUI   = 32'h123452B7;
    localparam logic [31:0] LBU   = 32'h0000C103;
    localparam logic [31:0] JAL   = 32'h0080006F;
    localparam logic [31:0] SUB   = 32'h40208133;
    localparam logic [31:0] SRAI  = 32'h4010D093;
    localparam logic [31:0] BNE   = 32'h00209463;
    localparam logic [31:0] ILL   = 32'hFFFFFFFF;
    localparam logic [31:0] BILL  = 32'h0020A463;

`ifdef INST_DECODER_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   chk_en   = 1'b0;

    inst_decoder_if bus ();

    inst_decoder #(.FLUSH_DEPTH(FLUSH_DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference decode from the instruction-class tables, 0 for illegal words
    function automatic logic model_ill(input logic [31:0] i);
        logic [2:0] f3;
        f3 = i[14:12];
        case (i[6:0])
            7'h37, 7'h17, 7'h6F, 7'h67, 7'h13, 7'h33, 7'h0F, 7'h73: return 1'b0;
            7'h63: return (f3 == 3'd2) || (f3 == 3'd3);
            7'h03: return !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
            7'h23: return !(f3 inside {3'd0, 3'd1, 3'd2});
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] model_mc(input logic [31:0] i);
        logic [2:0]  f3;
        logic [31:0] alu_tab [8];
        logic [31:0] cond_tab [8];
        logic [31:0] alu;
        f3 = i[14:12];
        alu_tab  = '{0, 2, 3, 4, 5, 6, 8, 9};
        cond_tab = '{1, 2, 0, 0, 3, 4, 5, 6};
        alu = alu_tab[f3];
        if (model_ill(i)) return 32'h0;
        case (i[6:0])
            7'h37: return 32'h00030000;
            7'h17: return 32'h00050208;
            7'h6F: return 32'hE0094210;
            7'h67: return 32'hE0094085;
            7'h63: return 32'h00004223 | (cond_tab[f3] << 29);
            7'h03: return 32'h00119085 | (f3 == 3'd0 ? 32'h00800000 : f3 == 3'd1 ? 32'h01000000 :
                                           f3 == 3'd4 ? 32'h00200000 : f3 == 3'd5 ? 32'h00400000 : 32'h0);
            7'h23: return 32'h0000B907 | (f3 == 3'd0 ? 32'h00200000 : f3 == 3'd1 ? 32'h00400000 : 32'h0);
            7'h13: begin
                if (f3 == 3'd5 && i[30]) alu = 7;
                return ((f3 == 3'd1 || f3 == 3'd5) ? 32'h00050405 : 32'h00050085) | (alu << 25);
            end
            7'h33: begin
                if (f3 == 3'd0 && i[30]) alu = 1;
                if (f3 == 3'd5 && i[30]) alu = 7;
                return 32'h00050047 | (alu << 25);
            end
            default: return 32'h0;
        endcase
    endfunction

    int          cyc = 0;
    int          last_jump = -1000;
    logic [31:0] exp_mc;
    logic [24:0] exp_data;
    logic        exp_ill;
    logic        m_squash;

    always_comb m_squash = bus.jump_taken || (cyc - last_jump < FLUSH_DEPTH) || bus.block_inst || exp_ill;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            exp_mc    <= 32'h0;
            exp_data  <= 25'h0;
            exp_ill   <= 1'b0;
            last_jump <= -1000;
        end else begin
            if (bus.jump_taken) last_jump <= cyc;
            if (m_squash || model_ill(bus.instruction)) begin
                exp_mc   <= 32'h0;
                exp_data <= 25'h0;
            end else begin
                exp_mc   <= model_mc(bus.instruction);
                exp_data <= bus.instruction[31:7];
            end
            if (TRAP && !m_squash && model_ill(bus.instruction)) exp_ill <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_checks++;
            if (bus.microcode_s0 === exp_mc && bus.instruction_data_s0 === exp_data &&
                bus.illegal_inst === exp_ill) begin
                n_pass++;
            end else begin
                $display("FAIL model cyc=%0d: got mc=%h data=%h ill=%b, want mc=%h data=%h ill=%b",
                         cyc, bus.microcode_s0, bus.instruction_data_s0, bus.illegal_inst,
                         exp_mc, exp_data, exp_ill);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] mc, input logic [24:0] data, input logic ill);
        n_checks++;
        if (bus.microcode_s0 === mc && bus.instruction_data_s0 === data && bus.illegal_inst === ill) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got mc=%h data=%h ill=%b, want mc=%h data=%h ill=%b", name,
                     bus.microcode_s0, bus.instruction_data_s0, bus.illegal_inst, mc, data, ill);
        end
    endtask

    task automatic drive(input logic [31:0] instr, input logic blk, input logic jmp);
        @(negedge clk);
        bus.instruction = instr;
        bus.block_inst  = blk;
        bus.jump_taken  = jmp;
    endtask

    task automatic step_chk(input logic [31:0] instr, input logic blk, input logic jmp, input string name,
                            input logic [31:0] mc, input logic [24:0] data, input logic ill);
        drive(instr, blk, jmp);
        @(posedge clk);
        #1;
        chk(name, mc, data, ill);
    endtask

    localparam logic [31:0] ADDI_MC = 32'h00050085;
    localparam logic [24:0] ADDI_D  = 25'h000A001;

    initial begin
        logic [31:0] mix [8];
        mix = '{SUB, SRAI, BNE, 32'h0020A223, 32'h000080E7, 32'h00001097, 32'h00009103, 32'h00209093};
        rst_n = 1'b0;
        bus.instruction = ADDI;
        bus.block_inst  = 1'b0;
        bus.jump_taken  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", 32'h0, 25'h0, 1'b0);
        chk_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        step_chk(ADDI, 0, 0, "addi", ADDI_MC, ADDI_D, 0);
        step_chk(LUI,  0, 0, "lui",  32'h00030000, 25'h02468A5, 0);
        step_chk(LBU,  0, 0, "lbu",  32'h00319085, 25'h0000182, 0);
        step_chk(JAL,  0, 0, "jal",  32'hE0094210, 25'h0010000, 0);

        step_chk(ADDI, 0, 1, "flush0", 32'h0, 25'h0, 0);
        step_chk(ADDI, 0, 0, "flush1", 32'h0, 25'h0, 0);
        step_chk(ADDI, 0, 0, "flush2", 32'h0, 25'h0, 0);
        step_chk(ADDI, 0, 0, "after_flush", ADDI_MC, ADDI_D, 0);

        drive(ADDI, 0, 1);
        drive(ADDI, 0, 0);
        drive(ADDI, 0, 1);
        step_chk(ADDI, 0, 0, "reflush1", 32'h0, 25'h0, 0);
        step_chk(ADDI, 0, 0, "reflush2", 32'h0, 25'h0, 0);
        step_chk(ADDI, 0, 0, "after_reflush", ADDI_MC, ADDI_D, 0);

        step_chk(ADDI, 1, 0, "block0", 32'h0, 25'h0, 0);
        step_chk(ADDI, 1, 0, "block1", 32'h0, 25'h0, 0);
        step_chk(LUI,  0, 0, "after_block", 32'h00030000, 25'h02468A5, 0);

        step_chk(SUB,  0, 0, "sub",  32'h02050047, SUB[31:7], 0);
        step_chk(SRAI, 0, 0, "srai", 32'h0E050405, SRAI[31:7], 0);
        step_chk(BNE,  0, 0, "bne",  32'h40004223, BNE[31:7], 0);
        foreach (mix[k]) drive(mix[k], 0, 0);
        drive(32'h0000000F, 0, 0);
        drive(32'h00000073, 0, 0);

        drive(ADDI, 0, 1);
        @(negedge clk);
        rst_n = 1'b0;
        bus.jump_taken = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_mid_flush", ADDI_MC, ADDI_D, 0);

        step_chk(ILL,  0, 0, "illegal", 32'h0, 25'h0, TRAP);
        step_chk(ADDI, 0, 0, "post_ill0", TRAP ? 32'h0 : ADDI_MC, TRAP ? 25'h0 : ADDI_D, TRAP);
        step_chk(LUI,  0, 0, "post_ill1", TRAP ? 32'h0 : 32'h00030000, TRAP ? 25'h0 : 25'h02468A5, TRAP);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step_chk(ADDI, 0, 0, "after_ill_reset", ADDI_MC, ADDI_D, 0);
        step_chk(ILL, 1, 0, "ill_blocked", 32'h0, 25'h0, 0);
        step_chk(BILL, 0, 0, "branch_f3_010", 32'h0, 25'h0, TRAP);
        drive(ADDI, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inst_decoder.md
# inst_decoder

Registered decode stage that feeds the control unit. Takes the raw RV32I instruction word from the synchronous instruction memory and produces the 32-bit microcode word and 25-bit instruction-data field consumed at s0. Inserts bubbles on pipeline block, taken jumps and illegal opcodes.

## Interface
Parameters:
- FLUSH_DEPTH, default 3: cycles of squash after a taken jump, covering the wrong-path fetches in si/s0/s1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- instruction  in  32  instruction word returned by instruction memory for the previous cycle's pc.
- block_inst  in  1  control-unit block (dependency, hold or memory busy).
- jump_taken  in  1  one-cycle pulse: jump_if_branch & branch resolved at s2.
- microcode_s0  out  32  registered microcode word.
- instruction_data_s0  out  25  registered instruction[31:7]; rd=[4:0], funct3=[7:5], rs1=[12:8], rs2=[17:13].
- illegal_inst  out  1  illegal-opcode flag (see Configuration).

## Operation
- Microcode bits: 0 chk_rs1, 1 chk_rs2, 2 rega→alu_a, 3 up→alu_a, 4 jt→alu_a, 5 bt→alu_a, 6 regb→alu_b, 7 li→alu_b, 8 st→alu_b, 9 pc→alu_b, 10 rs2→alu_b, 11 mem_we, 12 alu→mem_addr, 13 regb→mem_data, 14 jump_if_branch, 15 mem_in_use, 16 reg_we, 17 up→rd, 18 alu→rd, 19 ret→rd, 20 mem→rd, 21 byte/ubyte, 22 half/uhalf, 23 sbyte, 24 shalf, 28:25 alu_op, 31:29 branch_cond.
- alu_op: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9.
- branch_cond: 000 never, 001 eq, 010 ne, 011 lt, 100 ge, 101 ltu, 110 geu, 111 always.
- LUI: 16,17. AUIPC: 3,9,16,18, ADD. JAL: 4,9,14,16,19, ADD, cond 111 (0xE0094210). JALR: 0,2,7,14,16,19, ADD, cond 111.
- BRANCH: 0,1,5,9,14, ADD; funct3 000/001/100/101/110/111 map to cond 001..110. funct3 010/011 are illegal.
- LOAD: 0,2,7,12,15,16,20, ADD; LB adds 23, LH adds 24, LBU adds 21, LHU adds 22, LW adds none. Other funct3 values are illegal.
- STORE: 0,1,2,8,11,12,13,15, ADD; SB adds 21, SH adds 22, SW adds none. Other funct3 values are illegal.
- OP-IMM: 0,2,7,16,18, op from funct3. SLLI/SRLI/SRAI replace bit 7 with bit 10, and funct7[5] selects SRA.
- OP: 0,1,2,6,16,18, op from funct3; funct7[5] selects SUB/SRA.
- MISC-MEM, SYSTEM: legal, all-zero microcode.
- Any other opcode is illegal and decodes to all-zero microcode.
- Squash (both outputs loaded with 0) when any of the following holds: jump_taken, flush_cnt≠0, block_inst, or trap halt.
- flush_cnt: loads FLUSH_DEPTH−1 on jump_taken, otherwise decrements to 0 and saturates there.
- A jump_taken arriving during a flush reloads the counter.

## Timing
- Latency: instruction sampled at edge N appears on outputs after edge N.
- Squash inputs are sampled at the same edge and affect that edge's load only. There is no combinational path from block_inst or jump_taken to the outputs, which avoids a loop through data_dep.
- Reset: microcode_s0=0, instruction_data_s0=0, illegal_inst=0, flush_cnt=0.
- Reset asserted during a flush clears the counter, and decoding resumes on the first edge after release.
- Priority: reset > trap halt > jump_taken/flush > block_inst > decode.

## Configuration
- INST_DECODER_ILLEGAL_TRAP_EN defined:
  - An illegal instruction decoded unsquashed sets illegal_inst. The flag is sticky until reset.
  - From the next edge, all outputs are held at 0 (halt).
- Undefined: illegal instructions decode to a zero bubble, illegal_inst is tied to 0, and there is no halt.

## Structure
- control_pkg holds the microcode bit-index localparams, the alu_op and branch_cond enums, and the RV32I opcode constants. The control unit shares this package.
- Sub-module microcode_rom is purely combinational: instruction[31:0] → microcode[31:0] plus illegal. inst_decoder owns the registers, flush counter and trap.

## Test plan
- Reset: rst_n=0 with instruction=0x00500093 → all outputs 0.
- ADDI: 0x00500093 (addi x1,x0,5) → microcode_s0=0x00050085, instruction_data_s0=0x0A001 one edge later.
- LUI then LBU: 0x123452B7 → 0x00030000; 0x0000C103 → 0x00319085.
- Flush: JAL 0x0080006F → 0xE0094210, then jump_taken pulse → exactly 3 zero words, then normal decode. A second jump_taken mid-flush extends the flush.
- Block: block_inst=1 for 2 cycles with valid ADDI words → 2 zero words, then the next word decodes.
- Illegal: 0xFFFFFFFF.
  - With the macro: illegal_inst rises and stays high, and outputs stay 0 until rst_n=0.
  - Without: a single zero bubble and illegal_inst=0.
